// File: rtl/axil_cmd_master_if.sv
// Bus bundle for axil_cmd_master: command/response port plus
// the AXI4-lite master write and read channels.
interface axil_cmd_master_if #(
  parameter int ADDR_W = 3
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [31:0]       cmd_wdata;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_rdata;
  logic [1:0]        rsp_resp;
  logic              rsp_timeout;

  logic [ADDR_W-1:0] m_axi_awaddr;
  logic              m_axi_awvalid;
  logic              m_axi_awready;
  logic [31:0]       m_axi_wdata;
  logic              m_axi_wvalid;
  logic              m_axi_wready;
  logic [1:0]        m_axi_bresp;
  logic              m_axi_bvalid;
  logic              m_axi_bready;

  logic [ADDR_W-1:0] m_axi_araddr;
  logic              m_axi_arvalid;
  logic              m_axi_arready;
  logic [31:0]       m_axi_rdata;
  logic [1:0]        m_axi_rresp;
  logic              m_axi_rvalid;
  logic              m_axi_rready;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_resp, rsp_timeout,
    input  rsp_ready,
    output m_axi_awaddr, m_axi_awvalid,
    input  m_axi_awready,
    output m_axi_wdata, m_axi_wvalid,
    input  m_axi_wready,
    input  m_axi_bresp, m_axi_bvalid,
    output m_axi_bready,
    output m_axi_araddr, m_axi_arvalid,
    input  m_axi_arready,
    input  m_axi_rdata, m_axi_rresp, m_axi_rvalid,
    output m_axi_rready
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_resp, rsp_timeout,
    output rsp_ready,
    input  m_axi_awaddr, m_axi_awvalid,
    output m_axi_awready,
    input  m_axi_wdata, m_axi_wvalid,
    output m_axi_wready,
    output m_axi_bresp, m_axi_bvalid,
    input  m_axi_bready,
    input  m_axi_araddr, m_axi_arvalid,
    output m_axi_arready,
    output m_axi_rdata, m_axi_rresp, m_axi_rvalid,
    input  m_axi_rready
  );
endinterface

// File: rtl/axil_cmd_master.sv
// Single-outstanding AXI4-lite master: turns one command into one
// bus transaction and one response, aborting after TIMEOUT cycles.
module axil_cmd_master #(
  parameter int ADDR_W  = 3,
  parameter int TIMEOUT = 255
) (
  input logic               aclk,
  input logic               areset,
  axil_cmd_master_if.master bus
);
  typedef enum logic [2:0] {
    IDLE, WADDR, WRESP, RADDR, RDATA, RSP
  } state_t;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  state_t            state;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [15:0]       cnt;
  logic [15:0]       cnt_inc;
  logic              awvalid;
  logic              wvalid;
  logic              bready;
  logic              arvalid;
  logic              rready;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic [1:0]        rsp_resp;
  logic              rsp_timeout;
  logic              busy;
  logic              done;
  logic              tmo;
  logic              aw_ok;
  logic              w_ok;

  assign busy = (state == WADDR) || (state == WRESP) ||
                (state == RADDR) || (state == RDATA);
  assign cnt_inc = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
  // This cycle is the TIMEOUT-th one of the transaction
  assign tmo   = (cnt == TMO_LAST);
  assign aw_ok = !awvalid || bus.m_axi_awready;
  assign w_ok  = !wvalid || bus.m_axi_wready;

  always_comb begin
    done = 1'b0;
    unique case (state)
      WADDR:   done = aw_ok && w_ok;
      WRESP:   done = bus.m_axi_bvalid;
      RADDR:   done = bus.m_axi_arready;
      RDATA:   done = bus.m_axi_rvalid;
      default: done = 1'b0;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state       <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      cnt         <= '0;
      awvalid     <= 1'b0;
      wvalid      <= 1'b0;
      bready      <= 1'b0;
      arvalid     <= 1'b0;
      rready      <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_resp    <= '0;
      rsp_timeout <= 1'b0;
    end else if (busy && !done && tmo) begin
      awvalid     <= 1'b0;
      wvalid      <= 1'b0;
      bready      <= 1'b0;
      arvalid     <= 1'b0;
      rready      <= 1'b0;
      rsp_valid   <= 1'b1;
      rsp_resp    <= 2'b11;
      rsp_timeout <= 1'b1;
      state       <= RSP;
    end else begin
      if (busy) cnt <= cnt_inc;
      unique case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            addr_q  <= bus.cmd_addr;
            wdata_q <= bus.cmd_wdata;
            cnt     <= '0;
            if (bus.cmd_write) begin
              awvalid <= 1'b1;
              wvalid  <= 1'b1;
              state   <= WADDR;
            end else begin
              arvalid <= 1'b1;
              state   <= RADDR;
            end
          end
        end
        WADDR: begin
          if (bus.m_axi_awready) awvalid <= 1'b0;
          if (bus.m_axi_wready) wvalid <= 1'b0;
          if (done) begin
            bready <= 1'b1;
            state  <= WRESP;
          end
        end
        WRESP: begin
          if (done) begin
            bready      <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_rdata   <= '0;
            rsp_resp    <= bus.m_axi_bresp;
            rsp_timeout <= 1'b0;
            state       <= RSP;
          end
        end
        RADDR: begin
          if (done) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state   <= RDATA;
          end
        end
        RDATA: begin
          if (done) begin
            rready      <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_rdata   <= bus.m_axi_rdata;
            rsp_resp    <= bus.m_axi_rresp;
            rsp_timeout <= 1'b0;
            state       <= RSP;
          end
        end
        RSP: begin
          if (bus.rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.cmd_ready     = (state == IDLE);
  assign bus.rsp_valid     = rsp_valid;
  assign bus.rsp_rdata     = rsp_rdata;
  assign bus.rsp_resp      = rsp_resp;
  assign bus.rsp_timeout   = rsp_timeout;
  assign bus.m_axi_awaddr  = addr_q;
  assign bus.m_axi_awvalid = awvalid;
  assign bus.m_axi_wdata   = wdata_q;
  assign bus.m_axi_wvalid  = wvalid;
  assign bus.m_axi_bready  = bready;
  assign bus.m_axi_araddr  = addr_q;
  assign bus.m_axi_arvalid = arvalid;
  assign bus.m_axi_rready  = rready;
endmodule
